// File: rtl/therm_scan_ctrl_pkg.sv
// Shared types and constants for the ring-oscillator thermal scanner.
package therm_scan_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_COUNT  = 3'd2,
    ST_LATCH  = 3'd3,
    ST_SEND   = 3'd4,
    ST_NEXT   = 3'd5
  } state_t;

  localparam logic [7:0] FRAME_HDR = 8'hA5;

  function automatic int nbytes(input int w);
    return (w + 7) / 8;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/therm_scan_ctrl_if.sv
// UART-side byte stream: valid/ready handshake carrying one frame byte per transfer.
interface therm_scan_ctrl_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/therm_scan_ctrl_ro_sync_edge.sv
// Two-flop synchroniser for one raw RO output plus a registered rising-edge pulse.
module therm_scan_ctrl_ro_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic ro_in,
  output logic edge_pulse
);

  logic sync1_reg, sync2_reg, prev_reg, edge_reg;

  // Total latency from RO edge to pulse is three clocks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
      prev_reg  <= 1'b0;
      edge_reg  <= 1'b0;
    end else begin
      sync1_reg <= ro_in;
      sync2_reg <= sync1_reg;
      prev_reg  <= sync2_reg;
      edge_reg  <= sync2_reg & ~prev_reg;
    end
  end

  assign edge_pulse = edge_reg;

endmodule

// File: rtl/therm_scan_ctrl.sv
// Round-robin RO thermal scanner: settle, count edges over a window, latch, alarm, and stream a framed result.
module therm_scan_ctrl
  import therm_scan_ctrl_pkg::*;
#(
  parameter int N_CH          = 4,
  parameter int COUNT_W       = 16,
  parameter int WINDOW_CYCLES = 1000,
  parameter int SETTLE_CYCLES = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               single_shot,
  input  logic               start,
  input  logic [N_CH-1:0]    ro_in,
  output logic [N_CH-1:0]    ro_en,
  input  logic [COUNT_W-1:0] alarm_thresh,
  output logic [N_CH-1:0]    alarm,
  therm_scan_ctrl_if.master  tx,
  output logic               busy,
  output logic               scan_done
);

  localparam int NB    = nbytes(COUNT_W);
  localparam int TMR_W = $clog2(max2(WINDOW_CYCLES, SETTLE_CYCLES) + 1);
  localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int BI_W  = $clog2(NB + 2);

  localparam logic [TMR_W-1:0]   SETTLE_LOAD = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [TMR_W-1:0]   WINDOW_LOAD = TMR_W'(WINDOW_CYCLES - 1);
  localparam logic [CH_W-1:0]    CH_LAST     = CH_W'(N_CH - 1);
  localparam logic [BI_W-1:0]    BI_LAST     = BI_W'(NB + 1);
  localparam logic [COUNT_W-1:0] CNT_MAX     = '1;

  state_t               state_reg, state_next;
  logic [CH_W-1:0]      ch_reg, ch_next;
  logic [TMR_W-1:0]     tmr_reg, tmr_next;
  logic [COUNT_W-1:0]   count_reg, count_next;
  logic [COUNT_W-1:0]   result_reg, result_next;
  logic [BI_W-1:0]      bidx_reg, bidx_next;
  logic [N_CH-1:0]      alarm_reg, alarm_next;
  logic [N_CH-1:0]      ro_en_reg, ro_en_next;
  logic [7:0]           tx_data_reg, tx_data_next;
  logic                 tx_valid_reg, tx_valid_next;
  logic                 scan_done_reg, scan_done_next;
  logic [N_CH-1:0]      edge_vec;
  logic                 edge_sel;

  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_sync
      therm_scan_ctrl_ro_sync_edge u_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .ro_in      (ro_in[gi]),
        .edge_pulse (edge_vec[gi])
      );
    end
  endgenerate

  assign edge_sel = edge_vec[ch_reg];

  function automatic logic [N_CH-1:0] onehot(input logic [CH_W-1:0] c);
    logic [N_CH-1:0] r;
    for (int i = 0; i < N_CH; i++) r[i] = (c == CH_W'(i));
    return r;
  endfunction

  // Byte 0 is the header, byte 1 the channel, then the zero-padded result MSB first.
  function automatic logic [7:0] frame_byte(input logic [BI_W-1:0] idx,
                                            input logic [CH_W-1:0] c,
                                            input logic [COUNT_W-1:0] r);
    logic [NB*8-1:0] pad;
    logic [7:0]      b;
    pad = (NB*8)'(r);
    b   = FRAME_HDR;
    if (idx == BI_W'(1)) b = {4'h0, 4'(c)};
    for (int k = 0; k < NB; k++) begin
      if (idx == BI_W'(k + 2)) b = pad[8*(NB-1-k) +: 8];
    end
    return b;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      ch_reg        <= '0;
      tmr_reg       <= '0;
      count_reg     <= '0;
      result_reg    <= '0;
      bidx_reg      <= '0;
      alarm_reg     <= '0;
      ro_en_reg     <= '0;
      tx_data_reg   <= '0;
      tx_valid_reg  <= 1'b0;
      scan_done_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      ch_reg        <= ch_next;
      tmr_reg       <= tmr_next;
      count_reg     <= count_next;
      result_reg    <= result_next;
      bidx_reg      <= bidx_next;
      alarm_reg     <= alarm_next;
      ro_en_reg     <= ro_en_next;
      tx_data_reg   <= tx_data_next;
      tx_valid_reg  <= tx_valid_next;
      scan_done_reg <= scan_done_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    ch_next        = ch_reg;
    tmr_next       = tmr_reg;
    count_next     = count_reg;
    result_next    = result_reg;
    bidx_next      = bidx_reg;
    alarm_next     = alarm_reg;
    ro_en_next     = ro_en_reg;
    tx_data_next   = tx_data_reg;
    tx_valid_next  = tx_valid_reg;
    scan_done_next = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          state_next = ST_SETTLE;
          ch_next    = '0;
          tmr_next   = SETTLE_LOAD;
          ro_en_next = onehot('0);
          count_next = '0;
        end
      end
      ST_SETTLE: begin
        count_next = '0;
        if (tmr_reg == '0) begin
          state_next = ST_COUNT;
          tmr_next   = WINDOW_LOAD;
        end else begin
          tmr_next = tmr_reg - 1'b1;
        end
      end
      ST_COUNT: begin
        if (edge_sel && (count_reg != CNT_MAX)) count_next = count_reg + 1'b1;
        if (tmr_reg == '0) state_next = ST_LATCH;
        else               tmr_next   = tmr_reg - 1'b1;
      end
      ST_LATCH: begin
        result_next         = count_reg;
        alarm_next[ch_reg]  = (count_reg < alarm_thresh);
        ro_en_next          = '0;
        bidx_next           = '0;
        tx_data_next        = FRAME_HDR;
        tx_valid_next       = 1'b1;
        state_next          = ST_SEND;
      end
      ST_SEND: begin
        // Valid is held in SEND, so ready alone marks a transfer.
        if (tx.tx_ready) begin
          if (bidx_reg == BI_LAST) begin
            tx_valid_next = 1'b0;
            state_next    = ST_NEXT;
          end else begin
            bidx_next    = bidx_reg + 1'b1;
            tx_data_next = frame_byte(bidx_reg + 1'b1, ch_reg, result_reg);
          end
        end
      end
      ST_NEXT: begin
        if (ch_reg == CH_LAST) begin
          ch_next        = '0;
          scan_done_next = 1'b1;
          if (single_shot) begin
            state_next = ST_IDLE;
          end else begin
            state_next = ST_SETTLE;
            tmr_next   = SETTLE_LOAD;
            ro_en_next = onehot('0);
          end
        end else begin
          ch_next    = ch_reg + 1'b1;
          state_next = ST_SETTLE;
          tmr_next   = SETTLE_LOAD;
          ro_en_next = onehot(ch_reg + 1'b1);
        end
      end
      default: state_next = ST_IDLE;
    endcase

    // Disable aborts everything except the sticky alarms.
    if (!en) begin
      state_next     = ST_IDLE;
      ch_next        = '0;
      ro_en_next     = '0;
      tx_valid_next  = 1'b0;
      count_next     = '0;
      scan_done_next = 1'b0;
    end
  end

  assign ro_en       = ro_en_reg;
  assign alarm       = alarm_reg;
  assign tx.tx_data  = tx_data_reg;
  assign tx.tx_valid = tx_valid_reg;
  assign busy        = (state_reg != ST_IDLE);
  assign scan_done   = scan_done_reg;

endmodule

// File: tb/tb_therm_scan_ctrl.sv
// Scoreboard bench for therm_scan_ctrl: expected frames queued per scan, checked by an independent monitor.
module tb_therm_scan_ctrl;

  localparam int WIN = 100;
  localparam int NBY = 2;

  logic        clk;
  logic        rst_n, en, single_shot, start;
  logic [1:0]  ro_in, ro_en, alarm;
  logic [15:0] thresh;
  logic        busy, scan_done;

  logic        sat_en, sat_start, ro_fast;
  logic [1:0]  sat_ro, sat_ro_en, sat_alarm;
  logic        sat_busy, sat_done;

  therm_scan_ctrl_if tx_if ();
  therm_scan_ctrl_if sat_if ();

  assign sat_if.tx_ready = 1'b1;
  assign sat_ro          = {ro_fast, ro_fast};

  therm_scan_ctrl #(.N_CH(2), .COUNT_W(16), .WINDOW_CYCLES(100), .SETTLE_CYCLES(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .single_shot  (single_shot),
    .start        (start),
    .ro_in        (ro_in),
    .ro_en        (ro_en),
    .alarm_thresh (thresh),
    .alarm        (alarm),
    .tx           (tx_if),
    .busy         (busy),
    .scan_done    (scan_done)
  );

  therm_scan_ctrl #(.N_CH(2), .COUNT_W(8), .WINDOW_CYCLES(600), .SETTLE_CYCLES(8)) dut_sat (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (sat_en),
    .single_shot  (1'b1),
    .start        (sat_start),
    .ro_in        (sat_ro),
    .ro_en        (sat_ro_en),
    .alarm_thresh (8'hFF),
    .alarm        (sat_alarm),
    .tx           (sat_if),
    .busy         (sat_busy),
    .scan_done    (sat_done)
  );

  typedef struct {int ch; int lo; int hi;} frame_t;

  frame_t     exp_q[$];
  logic [7:0] sat_q[$];
  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int sat_bytes = 0;
  int flush_cnt = 0;
  int mon_pos = 0;
  int per [2] = '{10, 4};
  int ph  [2] = '{0, 0};
  int ready_mode = 0;
  int ready_pct = 100;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Sole driver of RO waveforms and tx_ready; updates 1 ns after each rising edge.
  initial begin : drv
    int cyc;
    cyc = 0;
    ro_in = 2'b00;
    ro_fast = 1'b0;
    tx_if.tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      for (int k = 0; k < 2; k++) ro_in[k] = (((cyc + ph[k]) % per[k]) < per[k] / 2);
      ro_fast = ~ro_fast;
      case (ready_mode)
        0:       tx_if.tx_ready = 1'b1;
        1:       tx_if.tx_ready = ($urandom_range(99) < ready_pct);
        2:       tx_if.tx_ready = 1'b0;
        default: tx_if.tx_ready = ((cyc % 3) == 0);
      endcase
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Main scoreboard monitor: reassembles frames from accepted bytes.
  initial begin : mon
    frame_t     f;
    int         acc, seen;
    logic       hold_p;
    logic [7:0] hold_d;
    seen = 0; acc = 0; hold_p = 1'b0; hold_d = 8'h00;
    f = '{-1, 0, 0};
    forever begin
      @(negedge clk);
      if (flush_cnt != seen) begin
        mon_pos = 0;
        seen    = flush_cnt;
      end
      if (hold_p && en && rst_n) begin
        total++;
        if (!(tx_if.tx_valid && tx_if.tx_data == hold_d)) begin
          bad++;
          $display("FAIL hold: got valid=%0b data=%02h expected valid=1 data=%02h",
                   tx_if.tx_valid, tx_if.tx_data, hold_d);
        end
      end
      hold_p = tx_if.tx_valid && !tx_if.tx_ready;
      hold_d = tx_if.tx_data;
      if (tx_if.tx_valid && tx_if.tx_ready && en && rst_n) begin
        total++;
        if (mon_pos == 0) begin
          if (exp_q.size() == 0) begin
            bad++;
            f = '{-1, 0, 0};
            $display("FAIL unexpected_frame: got byte %02h expected no frame", tx_if.tx_data);
          end else begin
            f = exp_q.pop_front();
            if (tx_if.tx_data != 8'hA5) begin
              bad++;
              $display("FAIL header: got %02h expected a5", tx_if.tx_data);
            end
          end
          acc = 0;
          mon_pos = 1;
        end else if (mon_pos == 1) begin
          if (int'(tx_if.tx_data) != f.ch) begin
            bad++;
            $display("FAIL channel: got %0d expected %0d", tx_if.tx_data, f.ch);
          end
          mon_pos = 2;
        end else begin
          acc = (acc << 8) | int'(tx_if.tx_data);
          if (mon_pos == NBY + 1) begin
            if (acc < f.lo || acc > f.hi) begin
              bad++;
              $display("FAIL count ch%0d: got %0d expected %0d..%0d", f.ch, acc, f.lo, f.hi);
            end
            $display("frame ch=%0d count=%0d", f.ch, acc);
            mon_pos = 0;
          end else begin
            mon_pos = mon_pos + 1;
          end
        end
      end
    end
  end

  initial begin : mon_done
    forever begin
      @(negedge clk);
      if (scan_done) done_cnt++;
    end
  end

  initial begin : mon_sat
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (sat_if.tx_valid && sat_if.tx_ready && rst_n) begin
        total++;
        if (sat_q.size() == 0) begin
          bad++;
          $display("FAIL sat_unexpected: got %02h expected nothing", sat_if.tx_data);
        end else begin
          e = sat_q.pop_front();
          if (sat_if.tx_data != e) begin
            bad++;
            $display("FAIL sat_byte%0d: got %02h expected %02h", sat_bytes, sat_if.tx_data, e);
          end
        end
        sat_bytes++;
      end
    end
  end

  function automatic int exp_lo(input int k);
    return WIN / per[k] - 1;
  endfunction

  function automatic int exp_hi(input int k);
    return (WIN + per[k] - 1) / per[k] + 1;
  endfunction

  // Alarm is only predictable when thresh lies outside each channel's count tolerance.
  function automatic logic [1:0] exp_alarm();
    logic [1:0] a;
    for (int k = 0; k < 2; k++) a[k] = (int'(thresh) > exp_hi(k));
    return a;
  endfunction

  task automatic push_scan();
    for (int k = 0; k < 2; k++) exp_q.push_back('{k, exp_lo(k), exp_hi(k)});
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget);
    int n;
    n = 0;
    while (done_cnt < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("scan_done_reached", 32'(done_cnt >= target), 32'd1);
  endtask

  task automatic flush();
    exp_q.delete();
    flush_cnt++;
  endtask

  task automatic scan_single(input string tag);
    int base;
    base = done_cnt;
    push_scan();
    pulse_start();
    wait_done(base + 1, 4000);
    repeat (3) @(negedge clk);
    chk({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    chk({tag, "_alarm"}, 32'(alarm), 32'(exp_alarm()));
    chk({tag, "_idle"}, 32'(busy), 32'd0);
    chk({tag, "_one_done"}, 32'(done_cnt - base), 32'd1);
  endtask

  task automatic pick_thresh();
    int  t;
    bit  ok;
    thresh = 16'd0;
    for (int tries = 0; tries < 50; tries++) begin
      t  = $urandom_range(70, 1);
      ok = 1'b1;
      for (int k = 0; k < 2; k++) if (!(t <= exp_lo(k) || t > exp_hi(k))) ok = 1'b0;
      if (ok) begin
        thresh = 16'(t);
        break;
      end
    end
  endtask

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin : main
    logic [1:0] alarm_before;
    int         n, base;
    rst_n = 1'b0; en = 1'b0; single_shot = 1'b1; start = 1'b0; thresh = 16'd0;
    sat_en = 1'b0; sat_start = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_ro_en", 32'(ro_en), 32'd0);
    chk("rst_alarm", 32'(alarm), 32'd0);
    chk("rst_tx_valid", 32'(tx_if.tx_valid), 32'd0);
    chk("rst_tx_data", 32'(tx_if.tx_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_scan_done", 32'(scan_done), 32'd0);

    @(posedge clk); #1 rst_n = 1'b1; en = 1'b1; sat_en = 1'b1;

    // Saturation instance runs alongside the first scans.
    sat_q.push_back(8'hA5); sat_q.push_back(8'h00); sat_q.push_back(8'hFF);
    sat_q.push_back(8'hA5); sat_q.push_back(8'h01); sat_q.push_back(8'hFF);
    @(posedge clk); #1 sat_start = 1'b1;
    @(posedge clk); #1 sat_start = 1'b0;

    per = '{10, 4}; ph = '{0, 0}; thresh = 16'd20; ready_mode = 0;
    scan_single("basic");
    chk("basic_alarm_const", 32'(alarm), 32'd1);

    ready_mode = 3;
    scan_single("ready_1of3");

    for (int it = 0; it < 6; it++) begin
      for (int k = 0; k < 2; k++) begin
        per[k] = 2 * $urandom_range(12, 1);
        ph[k]  = $urandom_range(per[k] - 1, 0);
      end
      pick_thresh();
      ready_pct  = $urandom_range(100, 30);
      ready_mode = 1;
      scan_single("random");
    end

    n = 0;
    while (sat_bytes < 6 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("sat_bytes", 32'(sat_bytes), 32'd6);
    chk("sat_alarm", 32'(sat_alarm), 32'd0);
    chk("sat_idle", 32'(sat_busy), 32'd0);

    // Abort during the second result byte of channel 0.
    per = '{10, 4}; ph = '{0, 0}; thresh = 16'd20; ready_mode = 0;
    push_scan();
    pulse_start();
    n = 0;
    while (mon_pos != 3 && n < 2000) begin
      @(negedge clk); #1;
      n++;
    end
    chk("abort_reached_byte3", 32'(mon_pos), 32'd3);
    ready_mode = 2;
    alarm_before = alarm;
    @(posedge clk); #1 en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("abort_tx_valid", 32'(tx_if.tx_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_ro_en", 32'(ro_en), 32'd0);
    chk("abort_alarm_kept", 32'(alarm), 32'(alarm_before));
    flush();
    pulse_start();
    repeat (2) @(negedge clk);
    chk("start_while_disabled", 32'(busy), 32'd0);
    @(posedge clk); #1 en = 1'b1; ready_mode = 0;
    scan_single("restart");

    // Continuous scanning, stopped by raising single_shot during the third scan.
    base = done_cnt;
    push_scan(); push_scan(); push_scan();
    single_shot = 1'b0;
    pulse_start();
    wait_done(base + 1, 4000);
    pulse_start();
    @(negedge clk);
    chk("cont_busy_after_start", 32'(busy), 32'd1);
    wait_done(base + 2, 4000);
    single_shot = 1'b1;
    wait_done(base + 3, 4000);
    repeat (400) @(negedge clk);
    chk("cont_done_count", 32'(done_cnt - base), 32'd3);
    chk("cont_idle", 32'(busy), 32'd0);
    chk("cont_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("cont_alarm", 32'(alarm), 32'(exp_alarm()));

    // Asynchronous reset in the middle of a count window.
    push_scan();
    pulse_start();
    n = 0;
    while (ro_en == 2'b00 && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (30) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_ro_en", 32'(ro_en), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_tx_valid", 32'(tx_if.tx_valid), 32'd0);
    chk("async_rst_alarm", 32'(alarm), 32'd0);
    chk("async_rst_tx_data", 32'(tx_if.tx_data), 32'd0);
    chk("async_rst_scan_done", 32'(scan_done), 32'd0);
    flush();
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
